// File: rtl/hist_eq_pkg.sv
// hist_eq_pkg: shared sizes, build FSM encoding and the LUT scale
// factor helper for histogram_equalizer.
package hist_eq_pkg;

   localparam int BINS  = 256;
   localparam int PIX_W = 8;
   localparam int BIN_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN
   } build_st_t;

   // ceil(255 * 2^sh / n)
   function automatic longint unsigned calc_recip(
      input longint unsigned n,
      input int              sh
   );
      return ((64'd255 << sh) + n - 64'd1) / n;
   endfunction

endpackage

// File: rtl/histogram_equalizer_if.sv
// histogram_equalizer_if: histogram RAM read bus between the
// equalizer (master) and the histogram calculator (slave).
interface histogram_equalizer_if
   import hist_eq_pkg::*;
();

   logic             hist_ready;
   logic [PIX_W-1:0] hist_addr_rd;
   logic [BIN_W-1:0] hist_data_rd;

   modport master (
      input  hist_ready,
      input  hist_data_rd,
      output hist_addr_rd
   );

   modport slave (
      output hist_ready,
      output hist_data_rd,
      input  hist_addr_rd
   );

endinterface

// File: rtl/dp_bram.sv
// dp_bram: simple dual-port RAM, port A write, port B registered
// read, single clock.
module dp_bram #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     i_we_a,
   input  logic [$clog2(DEPTH)-1:0] i_addr_a,
   input  logic [WIDTH-1:0]         i_din_a,
   input  logic [$clog2(DEPTH)-1:0] i_addr_b,
   output logic [WIDTH-1:0]         o_dout_b
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we_a)
         r_mem[i_addr_a] <= i_din_a;
      o_dout_b <= r_mem[i_addr_b];
   end

endmodule

// File: rtl/histogram_equalizer_lut_builder.sv
// hist_eq_lut_builder: reads 256 bins, accumulates the CDF and
// produces scaled, clamped LUT write beats.
module hist_eq_lut_builder
   import hist_eq_pkg::*;
#(
   parameter int NUM_PIXELS = 307200,
   parameter int CDF_W      = 24,
   parameter int RECIP_SH   = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   histogram_equalizer_if.master bus,
   output logic                  o_busy,
   output logic                  o_start,
   output logic                  o_done,
   output logic                  o_overrun,
   output logic                  o_we,
   output logic [PIX_W-1:0]      o_waddr,
   output logic [PIX_W-1:0]      o_wdata
);

   localparam int PROD_W = CDF_W + BIN_W;
   localparam logic [BIN_W-1:0] RECIP =
      BIN_W'(calc_recip(longint'(NUM_PIXELS), RECIP_SH));

   build_st_t        r_state, w_state_nxt;
   logic [PIX_W-1:0] r_addr, w_addr_nxt;
   logic [1:0]       r_drain, w_drain_nxt;
   logic             r_v1, r_v2, r_v3;
   logic [PIX_W-1:0] r_i1, r_i2, r_i3;
   logic [CDF_W-1:0] r_cdf;
   logic [PROD_W-1:0] r_prod;
   logic [PROD_W-1:0] w_shift;
   logic             r_overrun;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_drain <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_drain <= w_drain_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_drain_nxt = r_drain;
      o_start     = 1'b0;
      o_done      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.hist_ready) begin
               o_start     = 1'b1;
               w_state_nxt = ST_READ;
               w_addr_nxt  = '0;
            end
         end
         ST_READ: begin
            w_addr_nxt = r_addr + 8'd1;
            if (r_addr == 8'd255) begin
               w_state_nxt = ST_DRAIN;
               w_drain_nxt = '0;
            end
         end
         ST_DRAIN: begin
            w_drain_nxt = r_drain + 2'd1;
            if (r_drain == 2'd3) begin
               w_state_nxt = ST_IDLE;
               o_done      = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // c1 data -> c2 cdf -> c3 product -> LUT write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_v3      <= 1'b0;
         r_i1      <= '0;
         r_i2      <= '0;
         r_i3      <= '0;
         r_cdf     <= '0;
         r_prod    <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_v1 <= (r_state == ST_READ);
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         r_i1 <= r_addr;
         r_i2 <= r_i1;
         r_i3 <= r_i2;
         if (o_start)
            r_cdf <= '0;
         else if (r_v1)
            r_cdf <= r_cdf + CDF_W'(bus.hist_data_rd);
         r_prod <= PROD_W'(r_cdf) * PROD_W'(RECIP);
         if (bus.hist_ready && r_state != ST_IDLE)
            r_overrun <= 1'b1;
      end
   end

   assign w_shift = r_prod >> RECIP_SH;

   assign bus.hist_addr_rd = r_addr;
   assign o_busy    = (r_state != ST_IDLE);
   assign o_overrun = r_overrun;
   assign o_we      = r_v3;
   assign o_waddr   = r_i3;
   assign o_wdata   = (|w_shift[PROD_W-1:PIX_W]) ?
                      8'hFF : w_shift[PIX_W-1:0];

endmodule

// File: rtl/histogram_equalizer.sv
// histogram_equalizer: builds an equalization LUT from the frame
// histogram and remaps pixels. Option: HIST_EQ_DOUBLE_BUFFER_EN.
module histogram_equalizer
   import hist_eq_pkg::*;
#(
   parameter int NUM_PIXELS = 307200,
   parameter int CDF_W      = 24,
   parameter int RECIP_SH   = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   histogram_equalizer_if.master hist_bus,
   input  logic [PIX_W-1:0]      in_pixel,
   input  logic                  in_valid,
   input  logic                  end_of_frame,
   output logic [PIX_W-1:0]      out_pixel,
   output logic                  out_valid,
   output logic                  out_end_of_frame,
   output logic                  lut_busy,
   output logic                  lut_active,
   output logic                  hist_overrun
);

   logic             w_start, w_done, w_we;
   logic [PIX_W-1:0] w_bwaddr, w_wdata, w_lut_q;
   logic [PIX_W-1:0] r_pix0, r_pix1;
   logic             r_v0, r_v1, r_eof0, r_eof1;
   logic             r_sel0, r_sel1;
   logic             r_active, r_pend;
   logic             w_fall;

   hist_eq_lut_builder #(
      .NUM_PIXELS (NUM_PIXELS),
      .CDF_W      (CDF_W),
      .RECIP_SH   (RECIP_SH)
   ) u_builder (
      .clk       (clk),
      .rst       (rst),
      .bus       (hist_bus),
      .o_busy    (lut_busy),
      .o_start   (w_start),
      .o_done    (w_done),
      .o_overrun (hist_overrun),
      .o_we      (w_we),
      .o_waddr   (w_bwaddr),
      .o_wdata   (w_wdata)
   );

`ifdef HIST_EQ_DOUBLE_BUFFER_EN
   localparam int LUT_D = 2 * BINS;
   logic             r_bank, r_bank0;
   logic [PIX_W:0]   w_waddr, w_raddr;
   assign w_waddr = {~r_bank, w_bwaddr};
   assign w_raddr = {r_bank0, r_pix0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bank  <= 1'b0;
         r_bank0 <= 1'b0;
      end else begin
         if (w_fall && r_pend)
            r_bank <= ~r_bank;
         r_bank0 <= r_bank;
      end
   end
`else
   localparam int LUT_D = BINS;
   logic [PIX_W-1:0] w_waddr, w_raddr;
   assign w_waddr = w_bwaddr;
   assign w_raddr = r_pix0;
`endif

   dp_bram #(
      .DEPTH (LUT_D),
      .WIDTH (PIX_W)
   ) u_lut (
      .clk      (clk),
      .i_we_a   (w_we),
      .i_addr_a (w_waddr),
      .i_din_a  (w_wdata),
      .i_addr_b (w_raddr),
      .o_dout_b (w_lut_q)
   );

   assign w_fall = r_eof0 & ~end_of_frame;

   // a finished LUT waits for the next frame boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_active <= 1'b0;
         r_pend   <= 1'b0;
      end else begin
         if (w_start)
            r_pend <= 1'b0;
         else if (w_done)
            r_pend <= 1'b1;
         else if (w_fall)
            r_pend <= 1'b0;
`ifdef HIST_EQ_DOUBLE_BUFFER_EN
         if (w_fall && r_pend)
            r_active <= 1'b1;
`else
         if (w_start)
            r_active <= 1'b0;
         else if (w_fall && r_pend)
            r_active <= 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pix0 <= '0;
         r_pix1 <= '0;
         r_v0   <= 1'b0;
         r_v1   <= 1'b0;
         r_eof0 <= 1'b0;
         r_eof1 <= 1'b0;
         r_sel0 <= 1'b0;
         r_sel1 <= 1'b0;
      end else begin
         r_pix0 <= in_pixel;
         r_pix1 <= r_pix0;
         r_v0   <= in_valid;
         r_v1   <= r_v0;
         r_eof0 <= end_of_frame;
         r_eof1 <= r_eof0;
         r_sel0 <= r_active;
         r_sel1 <= r_sel0;
      end
   end

   assign out_pixel        = r_sel1 ? w_lut_q : r_pix1;
   assign out_valid        = r_v1;
   assign out_end_of_frame = r_eof1;
   assign lut_active       = r_active;

endmodule
